rspi_arbiter: RTL and testbench

//  Shares the single rspi spi_core and its flash/RAM chip-selects between two requesters.

---
 rtl/rspi_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_rspi_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rspi_arbiter.sv
// Two-requester arbiter sharing the rspi spi_core and its flash/RAM chip-selects.
// Optional RSPI_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed req0 priority.
module rspi_arbiter #(
  parameter int unsigned CS_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic [7:0] tx0,
  input  logic [7:0] tx1,
  input  logic       start0,
  input  logic       start1,
  input  logic       fclk0,
  input  logic       fclk1,
  input  logic       fce0,
  input  logic       fce1,
  input  logic       rce0,
  input  logic       rce1,
  output logic [7:0] rx0,
  output logic [7:0] rx1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] spi_data_tx,
  output logic       spi_txn_start,
  output logic       spi_force_clock,
  input  logic [7:0] spi_data_rx,
  input  logic       spi_txn_done,
  output logic       flash_ce_n,
  output logic       ram_ce_n,
  output logic [1:0] owner,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_DRAIN, S_GAP} state_t;

  localparam bit         NO_GAP   = (CS_GAP == 0);
  localparam logic [3:0] GAP_LAST = 4'(CS_GAP - 1);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic       sel_q, sel_d;
  logic       busy_q, busy_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] hold_tx_q, hold_tx_d;
  logic       hold_fclk_q, hold_fclk_d;
  logic       hold_fce_q, hold_fce_d;
  logic       hold_rce_q, hold_rce_d;
  logic       win;
`ifdef RSPI_ARB_ROUND_ROBIN_EN
  logic       last_q, last_d;
`endif

  logic [7:0] own_tx;
  logic       own_req, own_start, own_fclk, own_fce, own_rce;

  always_comb begin
    own_req   = sel_q ? req1   : req0;
    own_tx    = sel_q ? tx1    : tx0;
    own_start = sel_q ? start1 : start0;
    own_fclk  = sel_q ? fclk1  : fclk0;
    own_fce   = sel_q ? fce1   : fce0;
    own_rce   = sel_q ? rce1   : rce0;
  end

  always_comb begin
    spi_data_tx     = '0;
    spi_txn_start   = 1'b0;
    spi_force_clock = 1'b0;
    flash_ce_n      = 1'b1;
    ram_ce_n        = 1'b1;
    rx0             = '0;
    rx1             = '0;
    done0           = 1'b0;
    done1           = 1'b0;
    unique case (state_q)
      S_OWN: begin
        spi_data_tx     = own_tx;
        spi_txn_start   = own_start;
        spi_force_clock = own_fclk;
        flash_ce_n      = own_fce;
        ram_ce_n        = own_rce;
      end
      S_DRAIN: begin
        spi_data_tx     = hold_tx_q;
        spi_force_clock = hold_fclk_q;
        flash_ce_n      = hold_fce_q;
        ram_ce_n        = hold_rce_q;
      end
      default: ;
    endcase
    // The current or draining owner keeps receiving returned data.
    if (state_q == S_OWN || state_q == S_DRAIN) begin
      if (sel_q) begin
        rx1   = spi_data_rx;
        done1 = spi_txn_done;
      end else begin
        rx0   = spi_data_rx;
        done0 = spi_txn_done;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (spi_txn_start) busy_d = 1'b1;
    if (spi_txn_done && (state_q == S_OWN || state_q == S_DRAIN)) busy_d = 1'b0;
  end

  always_comb begin
`ifdef RSPI_ARB_ROUND_ROBIN_EN
    win = (req0 && req1) ? ~last_q : req1;
`else
    win = ~req0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    sel_d       = sel_q;
    gap_d       = gap_q;
    hold_tx_d   = hold_tx_q;
    hold_fclk_d = hold_fclk_q;
    hold_fce_d  = hold_fce_q;
    hold_rce_d  = hold_rce_q;
`ifdef RSPI_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          sel_d   = win;
          owner_d = win ? 2'b10 : 2'b01;
          state_d = S_OWN;
`ifdef RSPI_ARB_ROUND_ROBIN_EN
          last_d  = win;
`endif
        end
      end
      S_OWN: begin
        hold_tx_d   = own_tx;
        hold_fclk_d = own_fclk;
        hold_fce_d  = own_fce;
        hold_rce_d  = own_rce;
        if (!own_req) begin
          owner_d = '0;
          gap_d   = '0;
          if (busy_d)      state_d = S_DRAIN;
          else if (NO_GAP) state_d = S_IDLE;
          else             state_d = S_GAP;
        end
      end
      S_DRAIN: begin
        if (spi_txn_done) begin
          gap_d   = '0;
          state_d = NO_GAP ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      gap_q       <= '0;
      hold_tx_q   <= '0;
      hold_fclk_q <= 1'b0;
      hold_fce_q  <= 1'b1;
      hold_rce_q  <= 1'b1;
`ifdef RSPI_ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      gap_q       <= gap_d;
      hold_tx_q   <= hold_tx_d;
      hold_fclk_q <= hold_fclk_d;
      hold_fce_q  <= hold_fce_d;
      hold_rce_q  <= hold_rce_d;
`ifdef RSPI_ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign gnt0  = owner_q[0];
  assign gnt1  = owner_q[1];
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_rspi_arbiter.sv
// Bench for rspi_arbiter: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_rspi_arbiter;

  localparam int GAP = 2;
  localparam int P_IDLE = 0, P_OWN = 1, P_DRAIN = 2, P_GAP = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, req0, req1, start0, start1, fclk0, fclk1, fce0, fce1, rce0, rce1;
  logic [7:0] tx0, tx1, spi_data_rx;
  logic       spi_txn_done;
  logic       gnt0, gnt1, done0, done1, spi_txn_start, spi_force_clock, flash_ce_n, ram_ce_n, busy;
  logic [7:0] rx0, rx1, spi_data_tx;
  logic [1:0] owner;

  logic       z_req0, z_req1, z_start0, c0, c1;
  logic [7:0] c8;
  logic       z_gnt0, z_gnt1, z_done0, z_done1, z_start, z_fclk, z_fce, z_rce, z_busy;
  logic [7:0] z_rx0, z_rx1, z_tx;
  logic [1:0] z_owner;

  int n_tests = 0;
  int n_fail  = 0;

  rspi_arbiter #(.CS_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .tx0(tx0), .tx1(tx1), .start0(start0), .start1(start1), .fclk0(fclk0), .fclk1(fclk1),
    .fce0(fce0), .fce1(fce1), .rce0(rce0), .rce1(rce1), .rx0(rx0), .rx1(rx1),
    .done0(done0), .done1(done1), .spi_data_tx(spi_data_tx), .spi_txn_start(spi_txn_start),
    .spi_force_clock(spi_force_clock), .spi_data_rx(spi_data_rx), .spi_txn_done(spi_txn_done),
    .flash_ce_n(flash_ce_n), .ram_ce_n(ram_ce_n), .owner(owner), .busy(busy)
  );

  rspi_arbiter #(.CS_GAP(0)) dut_nogap (
    .clk(clk), .rst_n(rst_n), .req0(z_req0), .req1(z_req1), .gnt0(z_gnt0), .gnt1(z_gnt1),
    .tx0(c8), .tx1(c8), .start0(z_start0), .start1(c0), .fclk0(c0), .fclk1(c0),
    .fce0(c1), .fce1(c1), .rce0(c1), .rce1(c1), .rx0(z_rx0), .rx1(z_rx1),
    .done0(z_done0), .done1(z_done1), .spi_data_tx(z_tx), .spi_txn_start(z_start),
    .spi_force_clock(z_fclk), .spi_data_rx(c8), .spi_txn_done(c0),
    .flash_ce_n(z_fce), .ram_ce_n(z_rce), .owner(z_owner), .busy(z_busy)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns, what phase, how many gap cycles remain.
  int         m_phase = P_IDLE, m_who = 0, m_last = 1, m_gapleft = 0;
  bit         m_busy = 0, m_valid = 0;
  logic [7:0] h_tx;
  logic       h_fclk, h_fce, h_rce;

  task automatic model_step();
    logic [1:0] r, st, fc, fe, re;
    logic [7:0] txa [2];
    bit nb;
    int w;
    r = {req1, req0}; st = {start1, start0}; fc = {fclk1, fclk0};
    fe = {fce1, fce0}; re = {rce1, rce0}; txa[0] = tx0; txa[1] = tx1;
    if (!rst_n) begin
      m_phase = P_IDLE; m_who = 0; m_last = 1; m_gapleft = 0; m_busy = 0; m_valid = 1;
      return;
    end
    if (!m_valid) return;
    nb = m_busy;
    if (m_phase == P_OWN && st[m_who]) nb = 1;
    if (spi_txn_done && (m_phase == P_OWN || m_phase == P_DRAIN)) nb = 0;
    case (m_phase)
      P_IDLE: if (r != 2'b00) begin
`ifdef RSPI_ARB_ROUND_ROBIN_EN
        w = (r == 2'b11) ? 1 - m_last : (r[0] ? 0 : 1);
`else
        w = r[0] ? 0 : 1;
`endif
        m_who = w; m_last = w; m_phase = P_OWN;
      end
      P_OWN: if (!r[m_who]) begin
        h_tx = txa[m_who]; h_fclk = fc[m_who]; h_fce = fe[m_who]; h_rce = re[m_who];
        if (nb) m_phase = P_DRAIN;
        else begin m_gapleft = GAP; m_phase = (GAP == 0) ? P_IDLE : P_GAP; end
      end
      P_DRAIN: if (spi_txn_done) begin
        m_gapleft = GAP; m_phase = (GAP == 0) ? P_IDLE : P_GAP;
      end
      default: begin
        m_gapleft--;
        if (m_gapleft == 0) m_phase = P_IDLE;
      end
    endcase
    m_busy = nb;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [1:0] e_gnt, e_done, st, fc, fe, re;
    logic [15:0] e_rx;
    logic [7:0] e_tx;
    logic e_start, e_fclk, e_fce, e_rce;
    @(negedge clk);
    if (m_valid) begin
      st = {start1, start0}; fc = {fclk1, fclk0}; fe = {fce1, fce0}; re = {rce1, rce0};
      e_gnt = 2'b00; e_tx = 8'h00; e_start = 0; e_fclk = 0; e_fce = 1; e_rce = 1;
      e_rx = 16'h0000; e_done = 2'b00;
      if (m_phase == P_OWN) begin
        e_gnt = (m_who == 1) ? 2'b10 : 2'b01;
        e_tx = (m_who == 1) ? tx1 : tx0;
        e_start = st[m_who]; e_fclk = fc[m_who]; e_fce = fe[m_who]; e_rce = re[m_who];
      end else if (m_phase == P_DRAIN) begin
        e_tx = h_tx; e_fclk = h_fclk; e_fce = h_fce; e_rce = h_rce;
      end
      if (m_phase == P_OWN || m_phase == P_DRAIN) begin
        e_rx   = (m_who == 1) ? {spi_data_rx, 8'h00} : {8'h00, spi_data_rx};
        e_done = (m_who == 1) ? {spi_txn_done, 1'b0} : {1'b0, spi_txn_done};
      end
      chk("gnt", 16'({gnt1, gnt0}), 16'(e_gnt));
      chk("owner", 16'(owner), 16'(e_gnt));
      chk("busy", 16'(busy), 16'(m_busy));
      chk("spi_data_tx", 16'(spi_data_tx), 16'(e_tx));
      chk("spi_txn_start", 16'(spi_txn_start), 16'(e_start));
      chk("force_clock", 16'(spi_force_clock), 16'(e_fclk));
      chk("ce_n", 16'({flash_ce_n, ram_ce_n}), 16'({e_fce, e_rce}));
      chk("rx", {rx1, rx0}, e_rx);
      chk("done", 16'({done1, done0}), 16'(e_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 0; req0 = 0; req1 = 0; start0 = 0; start1 = 0; fclk0 = 0; fclk1 = 0;
    fce0 = 1; fce1 = 1; rce0 = 1; rce1 = 1; tx0 = 0; tx1 = 0; spi_data_rx = 0; spi_txn_done = 0;
    z_req0 = 0; z_req1 = 0; z_start0 = 0; c0 = 0; c1 = 1; c8 = 8'h00;
    tick(); tick();
    rst_n = 1;
    #1;
    chk("rst_owner", 16'(owner), 16'h0);
    chk("rst_gnt", 16'({gnt1, gnt0}), 16'h0);
    chk("rst_ce", 16'({flash_ce_n, ram_ce_n}), 16'h3);
    chk("rst_busy", 16'(busy), 16'h0);

    // Zero-gap build: release at N, pending req1 granted at N+2.
    z_req0 = 1;
    tick(); #1 chk("z_gnt0", 16'(z_gnt0), 16'h1);
    z_req0 = 0; z_req1 = 1;
    tick(); #1 chk("z_rel_gnt", 16'({z_gnt1, z_gnt0}), 16'h0);
    tick(); #1 chk("z_gnt1", 16'(z_gnt1), 16'h1);
    chk("z_owner", 16'(z_owner), 16'h2);
    z_req1 = 0;

    // req1 alone: grant, send A5, receive 3C.
    req1 = 1;
    tick(); #1 chk("s1_gnt1", 16'(gnt1), 16'h1);
    chk("s1_owner", 16'(owner), 16'h2);
    fce1 = 0; tx1 = 8'hA5; start1 = 1;
    #1 chk("s1_tx", 16'(spi_data_tx), 16'hA5);
    chk("s1_fce", 16'(flash_ce_n), 16'h0);
    tick(); start1 = 0;
    #1 chk("s1_busy", 16'(busy), 16'h1);
    spi_data_rx = 8'h3C; spi_txn_done = 1;
    #1 chk("s1_rx1", 16'(rx1), 16'h3C);
    chk("s1_done1", 16'(done1), 16'h1);
    chk("s1_rx0", 16'(rx0), 16'h0);
    tick(); spi_data_rx = 0; spi_txn_done = 0;
    #1 chk("s1_busy_clr", 16'(busy), 16'h0);

    // Idle release, then contention after the gap: req0 wins.
    req1 = 0; fce1 = 1;
    tick(); req0 = 1; req1 = 1;
    #1 chk("s2_rel", 16'({gnt1, gnt0}), 16'h0);
    tick();
    tick(); #1 chk("s2_idle", 16'({gnt1, gnt0}), 16'h0);
    tick(); #1 chk("s2_gnt0", 16'({gnt1, gnt0}), 16'h1);

    // Release with a byte in flight: drain holds CE, blocks start.
    fce0 = 0; tx0 = 8'h5A; start0 = 1;
    tick(); start0 = 0; req0 = 0;
    #1 chk("s3_busy", 16'(busy), 16'h1);
    tick(); fce0 = 1; start0 = 1; tx0 = 8'h00;
    #1 chk("s3_gnt", 16'({gnt1, gnt0}), 16'h0);
    chk("s3_ce_held", 16'(flash_ce_n), 16'h0);
    chk("s3_tx_held", 16'(spi_data_tx), 16'h5A);
    chk("s3_start_blk", 16'(spi_txn_start), 16'h0);
    tick(); start0 = 0;
    tick(); tick(); tick();
    spi_data_rx = 8'h77; spi_txn_done = 1;
    #1 chk("s3_rx0", 16'(rx0), 16'h77);
    chk("s3_done0", 16'({done1, done0}), 16'h1);
    tick(); spi_data_rx = 0; spi_txn_done = 0;
    #1 chk("s3_gap1_ce", 16'({flash_ce_n, ram_ce_n}), 16'h3);
    tick(); #1 chk("s3_gap2_ce", 16'({flash_ce_n, ram_ce_n}), 16'h3);
    tick(); #1 chk("s3_idle", 16'({gnt1, gnt0}), 16'h0);
    tick(); #1 chk("s3_gnt1", 16'(gnt1), 16'h1);

    // Non-owner start and done are not seen by req0.
    req0 = 1; start0 = 1;
    #1 chk("s4_start", 16'(spi_txn_start), 16'h0);
    spi_data_rx = 8'h11; spi_txn_done = 1;
    #1 chk("s4_done0", 16'(done0), 16'h0);
    tick(); start0 = 0; spi_txn_done = 0; spi_data_rx = 0;
    #1 chk("s4_busy", 16'(busy), 16'h0);

    // Reset in the middle of a busy transaction.
    fce1 = 0; tx1 = 8'hC3; start1 = 1;
    tick(); start1 = 0;
    #1 chk("s5_busy", 16'(busy), 16'h1);
    rst_n = 0;
    tick(); #1 chk("s5_gnt", 16'({gnt1, gnt0}), 16'h0);
    chk("s5_owner", 16'(owner), 16'h0);
    chk("s5_busy0", 16'(busy), 16'h0);
    chk("s5_ce", 16'({flash_ce_n, ram_ce_n}), 16'h3);
    chk("s5_tx", 16'(spi_data_tx), 16'h0);
    rst_n = 1; fce1 = 1;
    tick(); #1 chk("s5_regnt", 16'({gnt1, gnt0}), 16'h1);

    // Drop and re-raise req0 with req1 pending; re-arbitration after the gap.
    req0 = 0;
    tick(); req0 = 1;
    tick();
    tick(); #1 chk("s6_idle", 16'({gnt1, gnt0}), 16'h0);
    tick();
`ifdef RSPI_ARB_ROUND_ROBIN_EN
    #1 chk("s6_rr", 16'({gnt1, gnt0}), 16'h2);
`else
    #1 chk("s6_fixed", 16'({gnt1, gnt0}), 16'h1);
`endif
    req0 = 0; req1 = 0;
    repeat (6) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
